// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM states and requester ids.
package uart_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FULL     = 2'd1,
      LAUNCH   = 2'd2,
      WAIT_ACK = 2'd3
   } sched_state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester, input-buffer and transmitter signals of the UART transmit scheduler.
// master = requesters/buffer/UART side, slave = the scheduler itself.
interface uart_tx_scheduler_if #(
   parameter int DataWIDTH = 3
);
   logic [2**DataWIDTH-1:0] Req0_Pdata;
   logic                    Req0_ParityEn;
   logic                    Req0_ParBit;
   logic                    Req0_Valid;
   logic                    Req0_Ready;

   logic [2**DataWIDTH-1:0] Req1_Pdata;
   logic                    Req1_ParityEn;
   logic                    Req1_ParBit;
   logic                    Req1_Valid;
   logic                    Req1_Ready;

   logic [2**DataWIDTH-1:0] Buffer_Pdata_in;
   logic                    Buffer_ParityEn_in;
   logic                    Buffer_ParBit_in;
   logic                    Buffer_EN;

   logic                    Uart_Busy;
   logic                    Uart_DataValid;

   logic                    Grant_Id;
   logic                    Sched_Idle;
   logic                    Err_Timeout;

   modport master (
      output Req0_Pdata, Req0_ParityEn, Req0_ParBit, Req0_Valid,
      input  Req0_Ready,
      output Req1_Pdata, Req1_ParityEn, Req1_ParBit, Req1_Valid,
      input  Req1_Ready,
      input  Buffer_Pdata_in, Buffer_ParityEn_in, Buffer_ParBit_in, Buffer_EN,
      output Uart_Busy,
      input  Uart_DataValid, Grant_Id, Sched_Idle, Err_Timeout
   );

   modport slave (
      input  Req0_Pdata, Req0_ParityEn, Req0_ParBit, Req0_Valid,
      output Req0_Ready,
      input  Req1_Pdata, Req1_ParityEn, Req1_ParBit, Req1_Valid,
      output Req1_Ready,
      output Buffer_Pdata_in, Buffer_ParityEn_in, Buffer_ParBit_in, Buffer_EN,
      input  Uart_Busy,
      output Uart_DataValid, Grant_Id, Sched_Idle, Err_Timeout
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; priority flips to the loser on every accepted grant.
module rr_arbiter2
   import uart_pkg::*;
(
   input  logic       Sched_CLK,
   input  logic       Sched_RST_SYN,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic       winner,
   output logic [1:0] grant
);

   logic prio_reg;

   // With nothing valid the winner defaults to requester 0 so the data mux is stable.
   always_comb begin
      winner = REQ0;
      if (valid[prio_reg])
         winner = prio_reg;
      else if (valid[~prio_reg])
         winner = ~prio_reg;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_grant
         assign grant[gi] = valid[gi] && (winner == 1'(gi));
      end
   endgenerate

   always_ff @(posedge Sched_CLK) begin
      if (!Sched_RST_SYN)
         prio_reg <= REQ0;
      else if (accept)
         prio_reg <= ~winner;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two requesters onto the single-entry UART input buffer and
// sequences the buffer-to-transmitter hand-off with an ack timeout and retry.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int DataWIDTH  = 3,
   parameter int AckTimeout = 15
) (
   input logic                Sched_CLK,
   input logic                Sched_RST_SYN,
   uart_tx_scheduler_if.slave bus
);

   localparam int DW = 2**DataWIDTH;
   localparam int CW = $clog2(AckTimeout + 1);

   sched_state_t  state_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          grant_id_reg;
   logic          err_reg;
   logic          dv_reg;

   logic [1:0]    valid;
   logic [1:0]    grant;
   logic          winner;
   logic          open_slot;
   logic          load;

   logic [DW-1:0] pdata_mux;
   logic          pe_mux;
   logic          pb_mux;

   assign valid     = {bus.Req1_Valid, bus.Req0_Valid};
   // Ready is suppressed during reset even though the state register reads EMPTY.
   assign open_slot = Sched_RST_SYN && (state_reg == EMPTY);
   assign load      = open_slot && (|grant);
   assign cnt_next  = cnt_reg + CW'(1);

   rr_arbiter2 u_arb (
      .Sched_CLK     (Sched_CLK),
      .Sched_RST_SYN (Sched_RST_SYN),
      .valid         (valid),
      .accept        (load),
      .winner        (winner),
      .grant         (grant)
   );

   always_comb begin
      pdata_mux = bus.Req0_Pdata;
      pe_mux    = bus.Req0_ParityEn;
      pb_mux    = bus.Req0_ParBit;
      if (winner == REQ1) begin
         pdata_mux = bus.Req1_Pdata;
         pe_mux    = bus.Req1_ParityEn;
         pb_mux    = bus.Req1_ParBit;
      end
   end

   assign bus.Req0_Ready         = open_slot && grant[0];
   assign bus.Req1_Ready         = open_slot && grant[1];
   assign bus.Buffer_EN          = load;
   assign bus.Buffer_Pdata_in    = pdata_mux;
   assign bus.Buffer_ParityEn_in = pe_mux;
   assign bus.Buffer_ParBit_in   = pb_mux;
   assign bus.Uart_DataValid     = dv_reg;
   assign bus.Grant_Id           = grant_id_reg;
   assign bus.Err_Timeout        = err_reg;
   assign bus.Sched_Idle         = (state_reg == EMPTY);

   // dv_reg is raised on entry to LAUNCH so the launch pulse is a clean Moore output.
   always_ff @(posedge Sched_CLK) begin
      if (!Sched_RST_SYN) begin
         state_reg    <= EMPTY;
         cnt_reg      <= '0;
         grant_id_reg <= REQ0;
         err_reg      <= 1'b0;
         dv_reg       <= 1'b0;
      end else begin
         dv_reg <= 1'b0;
         case (state_reg)
            EMPTY: begin
               if (load) begin
                  grant_id_reg <= winner;
                  state_reg    <= FULL;
               end
            end
            FULL: begin
               if (!bus.Uart_Busy) begin
                  state_reg <= LAUNCH;
                  dv_reg    <= 1'b1;
               end
            end
            LAUNCH: begin
               cnt_reg   <= '0;
               state_reg <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // Busy rising means the transmitter has captured the byte; buffer is free.
               if (bus.Uart_Busy) begin
                  state_reg <= EMPTY;
               end else begin
                  cnt_reg <= cnt_next;
                  if (cnt_next == CW'(AckTimeout)) begin
                     err_reg   <= 1'b1;
                     state_reg <= FULL;
                  end
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected loads/launches,
// a monitor pops and compares on Buffer_EN and Uart_DataValid.
module tb_uart_tx_scheduler;
   import uart_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       pb;
      logic       id;
   } load_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   load_t      load_q[$];
   logic [7:0] launch_q[$];
   logic [7:0] buf_data;

   bit model_on;
   int frame_len;
   int pend;
   int busy_left;

   uart_tx_scheduler_if #(.DataWIDTH(3)) bus ();

   uart_tx_scheduler #(
      .DataWIDTH  (3),
      .AckTimeout (15)
   ) dut (
      .Sched_CLK     (clk),
      .Sched_RST_SYN (rst_n),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input string msg);
      total++;
      bad++;
      $display("FAIL %s: %s at %0t", name, msg, $time);
   endtask

   // UART model: Busy rises one cycle after a launch and stays high frame_len cycles.
   initial begin
      bus.Uart_Busy = 1'b0;
      pend          = 0;
      busy_left     = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!model_on) begin
            bus.Uart_Busy = 1'b0;
            pend          = 0;
            busy_left     = 0;
         end else begin
            if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0) bus.Uart_Busy = 1'b0;
            end
            if (pend != 0) begin
               pend          = 0;
               bus.Uart_Busy = 1'b1;
               busy_left     = frame_len;
            end
            if (bus.Uart_DataValid) pend = 1;
         end
      end
   end

   // Monitor: compares every buffer load and every launch against the queues.
   initial begin
      logic  gid_pend;
      logic  gid_exp;
      load_t e;
      logic [7:0] l;
      gid_pend = 1'b0;
      gid_exp  = 1'b0;
      buf_data = 8'h00;
      forever begin
         @(negedge clk);
         if (gid_pend) begin
            check("grant_id", bus.Grant_Id, gid_exp);
            gid_pend = 1'b0;
         end
         if (bus.Buffer_EN) begin
            if (load_q.size() == 0) begin
               fail_now("load_unexpected", $sformatf("got %0h expected no load", bus.Buffer_Pdata_in));
            end else begin
               e = load_q.pop_front();
               $display("load   data=%02h pe=%0b pb=%0b id=%0d", bus.Buffer_Pdata_in,
                        bus.Buffer_ParityEn_in, bus.Buffer_ParBit_in, e.id);
               check("load_data", bus.Buffer_Pdata_in, e.d);
               check("load_parity", {bus.Buffer_ParityEn_in, bus.Buffer_ParBit_in}, {e.pe, e.pb});
               check("load_ready", {bus.Req1_Ready, bus.Req0_Ready}, e.id ? 2'b10 : 2'b01);
               gid_exp  = e.id;
               gid_pend = 1'b1;
            end
            buf_data = bus.Buffer_Pdata_in;
         end
         if (bus.Uart_DataValid) begin
            if (launch_q.size() == 0) begin
               fail_now("launch_unexpected", $sformatf("got %0h expected no launch", buf_data));
            end else begin
               l = launch_q.pop_front();
               $display("launch data=%02h", buf_data);
               check("launch_data", buf_data, l);
            end
         end
      end
   end

   task automatic push_exp(input logic [7:0] d, input logic pe, input logic pb, input logic id);
      load_t e;
      e.d = d; e.pe = pe; e.pb = pb; e.id = id;
      load_q.push_back(e);
      launch_q.push_back(d);
   endtask

   task automatic wait_hs(input string name, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (bus.Buffer_EN) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now(name, "timeout waiting for handshake");
   endtask

   task automatic wait_quiet(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.Sched_Idle && !bus.Uart_Busy && pend == 0 && busy_left == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now(name, "timeout waiting for idle");
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #1;
      rst_n          = 1'b0;
      bus.Req0_Valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check({name, "_idle"},  bus.Sched_Idle, 1'b1);
      check({name, "_dv"},    bus.Uart_DataValid, 1'b0);
      check({name, "_err"},   bus.Err_Timeout, 1'b0);
      check({name, "_gid"},   bus.Grant_Id, 1'b0);
      check({name, "_bufen"}, bus.Buffer_EN, 1'b0);
      check({name, "_rdy0"},  bus.Req0_Ready, 1'b0);
      bus.Req0_Valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      int fallen;
      bit dv_seen;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      model_on  = 1'b0;
      frame_len = 3;
      bus.Req0_Pdata = 8'h00; bus.Req0_ParityEn = 1'b0; bus.Req0_ParBit = 1'b0; bus.Req0_Valid = 1'b0;
      bus.Req1_Pdata = 8'h00; bus.Req1_ParityEn = 1'b0; bus.Req1_ParBit = 1'b0; bus.Req1_Valid = 1'b0;

      do_reset("rst0");

      // Single request, UART idle; latency relative to the handshake cycle t.
      model_on  = 1'b1;
      frame_len = 3;
      @(posedge clk); #1;
      push_exp(8'hA5, 1'b1, 1'b0, REQ0);
      bus.Req0_Pdata = 8'hA5; bus.Req0_ParityEn = 1'b1; bus.Req0_ParBit = 1'b0; bus.Req0_Valid = 1'b1;
      wait_hs("single_hs", 20, ok);
      check("single_rdy1", bus.Req1_Ready, 1'b0);
      @(posedge clk); #1;
      bus.Req0_Valid = 1'b0;
      @(negedge clk);
      check("single_dv_t1", bus.Uart_DataValid, 1'b0);
      check("single_full_t1", bus.Sched_Idle, 1'b0);
      @(negedge clk);
      check("single_dv_t2", bus.Uart_DataValid, 1'b1);
      @(negedge clk);
      check("single_dv_t3", bus.Uart_DataValid, 1'b0);
      @(negedge clk);
      check("single_idle_t4", bus.Sched_Idle, 1'b1);
      wait_quiet("single_quiet");

      // Reset restores priority to requester 0 before the alternation test.
      model_on = 1'b0;
      do_reset("rst1");

      // Both requesters continuously valid: strict alternation 11,22,11,22.
      model_on  = 1'b1;
      frame_len = 10;
      push_exp(8'h11, 1'b0, 1'b0, REQ0);
      push_exp(8'h22, 1'b1, 1'b1, REQ1);
      push_exp(8'h11, 1'b0, 1'b0, REQ0);
      push_exp(8'h22, 1'b1, 1'b1, REQ1);
      @(posedge clk); #1;
      bus.Req0_Pdata = 8'h11; bus.Req0_ParityEn = 1'b0; bus.Req0_ParBit = 1'b0; bus.Req0_Valid = 1'b1;
      bus.Req1_Pdata = 8'h22; bus.Req1_ParityEn = 1'b1; bus.Req1_ParBit = 1'b1; bus.Req1_Valid = 1'b1;
      n = 0;
      for (int i = 0; i < 400 && n < 4; i++) begin
         @(negedge clk);
         if (bus.Buffer_EN) n++;
      end
      if (n < 4) fail_now("rr_loads", $sformatf("got %0d loads expected 4", n));
      @(posedge clk); #1;
      bus.Req0_Valid = 1'b0;
      bus.Req1_Valid = 1'b0;
      wait_quiet("rr_quiet");

      // Queue during busy: second byte accepted while the first frame shifts out.
      frame_len = 20;
      push_exp(8'h5A, 1'b0, 1'b1, REQ0);
      push_exp(8'h3C, 1'b1, 1'b1, REQ1);
      @(posedge clk); #1;
      bus.Req0_Pdata = 8'h5A; bus.Req0_ParityEn = 1'b0; bus.Req0_ParBit = 1'b1; bus.Req0_Valid = 1'b1;
      wait_hs("queue_hs0", 20, ok);
      @(posedge clk); #1;
      bus.Req0_Valid = 1'b0;
      bus.Req1_Pdata = 8'h3C; bus.Req1_ParityEn = 1'b1; bus.Req1_ParBit = 1'b1; bus.Req1_Valid = 1'b1;
      wait_hs("queue_hs1", 40, ok);
      check("queue_busy_at_accept", bus.Uart_Busy, 1'b1);
      @(posedge clk); #1;
      bus.Req1_Valid = 1'b0;
      fallen  = -1;
      dv_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (fallen < 0) begin
            if (bus.Uart_Busy) begin
               if (bus.Uart_DataValid) dv_seen = 1'b1;
            end else begin
               fallen = i;
               check("queue_dv_while_busy", dv_seen, 1'b0);
               check("queue_dv_at_fall", bus.Uart_DataValid, 1'b0);
               check("queue_held_full", bus.Sched_Idle, 1'b0);
            end
         end else begin
            check("queue_dv_after_fall", bus.Uart_DataValid, 1'b1);
            break;
         end
      end
      if (fallen < 0) fail_now("queue_busy_fall", "Busy never fell");
      wait_quiet("queue_quiet");

      // Timeout: Busy stuck low, sticky error after 15 waiting cycles, then retry.
      model_on = 1'b0;
      load_q.push_back('{d: 8'h77, pe: 1'b0, pb: 1'b1, id: REQ1});
      launch_q.push_back(8'h77);
      launch_q.push_back(8'h77);
      @(posedge clk); #1;
      bus.Req1_Pdata = 8'h77; bus.Req1_ParityEn = 1'b0; bus.Req1_ParBit = 1'b1; bus.Req1_Valid = 1'b1;
      wait_hs("to_hs", 20, ok);
      @(posedge clk); #1;
      bus.Req1_Valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.Uart_DataValid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("to_first_dv", "no launch");
      check("to_err_before", bus.Err_Timeout, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 15) check("to_err_l15", bus.Err_Timeout, 1'b0);
         if (k == 16) check("to_err_l16", bus.Err_Timeout, 1'b1);
         if (k == 17) begin
            check("to_retry_dv", bus.Uart_DataValid, 1'b1);
            check("to_err_sticky", bus.Err_Timeout, 1'b1);
         end
      end
      @(negedge clk);
      check("to_err_sticky2", bus.Err_Timeout, 1'b1);

      // Reset in WAIT_ACK: sequence aborted and the buffered byte never relaunched.
      do_reset("rst2");
      dv_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.Uart_DataValid) dv_seen = 1'b1;
      end
      check("rst2_no_relaunch", dv_seen, 1'b0);

      // Withdrawn request: Req1 valid only while FULL, so no transfer and Prio unchanged.
      model_on  = 1'b1;
      frame_len = 5;
      push_exp(8'h99, 1'b1, 1'b0, REQ0);
      @(posedge clk); #1;
      bus.Req0_Pdata = 8'h99; bus.Req0_ParityEn = 1'b1; bus.Req0_ParBit = 1'b0; bus.Req0_Valid = 1'b1;
      wait_hs("wd_hs", 20, ok);
      @(posedge clk); #1;
      bus.Req0_Valid = 1'b0;
      bus.Req1_Pdata = 8'hEE; bus.Req1_ParityEn = 1'b0; bus.Req1_ParBit = 1'b0; bus.Req1_Valid = 1'b1;
      @(negedge clk);
      check("wd_rdy1_full", bus.Req1_Ready, 1'b0);
      check("wd_bufen_full", bus.Buffer_EN, 1'b0);
      @(posedge clk); #1;
      bus.Req1_Valid = 1'b0;
      wait_quiet("wd_quiet");
      // Priority still points at requester 1 after the withdrawn attempt.
      push_exp(8'h02, 1'b1, 1'b0, REQ1);
      @(posedge clk); #1;
      bus.Req0_Pdata = 8'h01; bus.Req0_ParityEn = 1'b0; bus.Req0_ParBit = 1'b0; bus.Req0_Valid = 1'b1;
      bus.Req1_Pdata = 8'h02; bus.Req1_ParityEn = 1'b1; bus.Req1_ParBit = 1'b0; bus.Req1_Valid = 1'b1;
      wait_hs("wd_prio_hs", 20, ok);
      check("wd_prio_rdy0", bus.Req0_Ready, 1'b0);
      @(posedge clk); #1;
      bus.Req0_Valid = 1'b0;
      bus.Req1_Valid = 1'b0;
      wait_quiet("wd_prio_quiet");

      check("load_q_drained", load_q.size(), 0);
      check("launch_q_drained", launch_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
